toggle_stream_decoder: RTL and testbench

- Receive-side counterpart of the team's D-to-T conversion flip-flop.
- Accepts a serial toggle-encoded bit stream, where each t bit means "toggle the line level", and rebuilds the level sequence with a T flip-flop made from a D register (q_next = q ^ t).
- Packs the rebuilt levels into WIDTH-bit words and presents them on a valid/ready output with a one-word holding buffer.
- Sits between a toggle-encoded serial source and a word-wide consumer.

---
 rtl/toggle_stream_decoder.sv | 196 +++++++++++++++++++
 tb/tb_toggle_stream_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_stream_decoder.sv
// -----------------------------------------------------------------------------
// toggle_stream_decoder
//
// Receive-side counterpart of the D-to-T conversion flip-flop. A serial stream
// of toggle bits (1 = invert line level, 0 = hold) is turned back into line
// levels by a T flip-flop built from a D register (q_next = q ^ t). The
// rebuilt levels are packed LSB-first into WIDTH-bit words and offered on a
// valid/ready output backed by a one-word holding buffer. The input stream is
// never stalled: a word that completes while the buffer is still occupied and
// not being consumed is dropped and flagged on the sticky overflow output.
//
// Parameters:
//   WIDTH      bits per output word (2..32)
//   INIT_LEVEL line level after reset
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   t_in        toggle bit
//   t_valid     t_in valid this cycle (always accepted)
//   level_out   current reconstructed line level
//   word_out    reconstructed word, LSB = first received bit
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer accepts word_out
//   overflow    sticky, a completed word was dropped
//   clr_ovf     clears overflow (a simultaneous drop wins)
//   tcount      number of t_in=1 bits in the word on word_out
//               (only when TOGGLE_STREAM_DECODER_TCOUNT_EN is defined)
//
// Optional feature macro: TOGGLE_STREAM_DECODER_TCOUNT_EN
// -----------------------------------------------------------------------------
module toggle_stream_decoder #(
   parameter int   WIDTH      = 8,
   parameter logic INIT_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t_in,
   input  logic             t_valid,
   output logic             level_out,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overflow,
   input  logic             clr_ovf
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] tcount
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   logic             q_r;
   logic [CW-1:0]    bit_cnt_r;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] word_r;
   logic             word_valid_r;
   logic             overflow_r;
   state_t           state_r;
   state_t           state_nxt_s;

   logic             d_s;
   logic             complete_s;
   logic [WIDTH-1:0] assembled_s;
   logic             load_s;
   logic             drop_s;

   // Post-update level of the current bit and the word as it would look with
   // that bit inserted; a completing word is taken from here so the last bit
   // does not have to pass through shift_r first.
   always_comb begin
      d_s         = q_r ^ t_in;
      assembled_s = shift_r;
      complete_s  = 1'b0;
      if (t_valid) begin
         assembled_s[bit_cnt_r] = d_s;
         complete_s             = (bit_cnt_r == LAST_IDX);
      end else begin
         assembled_s = shift_r;
         complete_s  = 1'b0;
      end
   end

   // Line-level T flip-flop and word assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r       <= INIT_LEVEL;
         bit_cnt_r <= {CW{1'b0}};
         shift_r   <= {WIDTH{1'b0}};
      end else if (t_valid) begin
         q_r       <= d_s;
         shift_r   <= assembled_s;
         bit_cnt_r <= complete_s ? {CW{1'b0}} : (bit_cnt_r + {{(CW-1){1'b0}}, 1'b1});
      end
   end

   // Holding-buffer FSM: decides whether a completing word is loaded or dropped.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         EMPTY: begin
            if (complete_s) begin
               load_s      = 1'b1;
               state_nxt_s = FULL;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         FULL: begin
            if (complete_s) begin
               // Consumer taking the old word frees the slot in the same cycle.
               if (word_ready) begin
                  load_s = 1'b1;
               end else begin
                  drop_s = 1'b1;
               end
               state_nxt_s = FULL;
            end else if (word_ready) begin
               state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = FULL;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
         end
      endcase
   end

   // Output buffer, valid flag and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= EMPTY;
         word_r       <= {WIDTH{1'b0}};
         word_valid_r <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         word_valid_r <= (state_nxt_s == FULL);
         if (load_s) begin
            word_r <= assembled_s;
         end
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign level_out  = q_r;
   assign word_out   = word_r;
   assign word_valid = word_valid_r;
   assign overflow   = overflow_r;

`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
   localparam int TCW = $clog2(WIDTH + 1);

   logic [TCW-1:0] tc_run_r;
   logic [TCW-1:0] tcount_r;
   logic [TCW-1:0] tc_sum_s;

   // Running toggle count including the current bit.
   always_comb begin
      tc_sum_s = tc_run_r + {{(TCW-1){1'b0}}, t_in};
   end

   // Toggle counter: restarts at each word boundary, latched with word_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         tc_run_r <= {TCW{1'b0}};
         tcount_r <= {TCW{1'b0}};
      end else begin
         if (t_valid) begin
            tc_run_r <= complete_s ? {TCW{1'b0}} : tc_sum_s;
         end
         if (load_s) begin
            tcount_r <= tc_sum_s;
         end
      end
   end

   assign tcount = tcount_r;
`endif

endmodule

// File: tb/tb_toggle_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_stream_decoder
//
// Directed bench for toggle_stream_decoder (WIDTH=8). dut0 uses INIT_LEVEL=0,
// dut1 uses INIT_LEVEL=1 for the mid-word reset case. Expected values are
// hand-computed: t stream 1,0,0,1,1,0,1,0 (8'h59 LSB first) from level 0
// gives levels 1,1,1,0,1,1,0,0 = 8'h37 with four toggles.
// -----------------------------------------------------------------------------
module tb_toggle_stream_decoder;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // dut0 (INIT_LEVEL = 0)
   logic       reset, t_in, t_valid, word_ready, clr_ovf;
   logic       level_out, word_valid, overflow;
   logic [7:0] word_out;
   // dut1 (INIT_LEVEL = 1)
   logic       reset1, t1_in, t1_valid, word1_ready, clr1_ovf;
   logic       level1_out, word1_valid, overflow1;
   logic [7:0] word1_out;
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
   logic [3:0] tcount, tcount1;
`endif

   int tests_run = 0;
   int fail_cnt  = 0;

   localparam logic [7:0] PAT_T   = 8'h59;
   localparam logic [7:0] PAT_LVL = 8'h37;

   toggle_stream_decoder #(.WIDTH(8), .INIT_LEVEL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .t_in(t_in), .t_valid(t_valid),
      .level_out(level_out), .word_out(word_out), .word_valid(word_valid),
      .word_ready(word_ready), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      , .tcount(tcount)
`endif
   );

   toggle_stream_decoder #(.WIDTH(8), .INIT_LEVEL(1'b1)) dut1 (
      .clk(clk), .reset(reset1), .t_in(t1_in), .t_valid(t1_valid),
      .level_out(level1_out), .word_out(word1_out), .word_valid(word1_valid),
      .word_ready(word1_ready), .overflow(overflow1), .clr_ovf(clr1_ovf)
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      , .tcount(tcount1)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic t);
      t_in    = t;
      t_valid = 1'b1;
      step();
      t_valid = 1'b0;
      t_in    = 1'b0;
   endtask

   task automatic send1(input logic t);
      t1_in    = t;
      t1_valid = 1'b1;
      step();
      t1_valid = 1'b0;
      t1_in    = 1'b0;
   endtask

   // Sends the 8'h59 pattern on dut0; checks word_valid stays low until the end.
   task automatic send_pat(input string tag);
      for (int i = 0; i < 8; i++) begin
         send0(PAT_T[i]);
         if (i < 7) check_val({tag, "_early_valid"}, {31'd0, word_valid}, 32'd0);
      end
   endtask

   initial begin
      logic [7:0] pat_t;
      logic [7:0] pat_lvl;
      logic [4:0] t1_bits;
      pat_t   = PAT_T;
      pat_lvl = PAT_LVL;
      t1_bits = 5'b01101;

      reset = 1'b1; t_in = 1'b0; t_valid = 1'b0; word_ready = 1'b0; clr_ovf = 1'b0;
      reset1 = 1'b1; t1_in = 1'b0; t1_valid = 1'b0; word1_ready = 1'b1; clr1_ovf = 1'b0;

      // 1: reset state
      step(); step();
      reset = 1'b0; reset1 = 1'b0;
      check_val("rst_level", {31'd0, level_out}, 32'd0);
      check_val("rst_valid", {31'd0, word_valid}, 32'd0);
      check_val("rst_ovf",   {31'd0, overflow}, 32'd0);
      check_val("rst_word",  {24'd0, word_out}, 32'h00);
      check_val("rst1_level", {31'd0, level1_out}, 32'd1);

      // 2: back-to-back stream, consumer ready
      word_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send0(pat_t[i]);
         check_val("t2_level", {31'd0, level_out}, {31'd0, pat_lvl[i]});
         check_val("t2_valid", {31'd0, word_valid}, (i == 7) ? 32'd1 : 32'd0);
      end
      check_val("t2_word", {24'd0, word_out}, 32'h37);
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      check_val("t2_tcount", {28'd0, tcount}, 32'd4);
`endif
      step();
      check_val("t2_consumed", {31'd0, word_valid}, 32'd0);

      // 3: same stream with 3 idle cycles between bits
      for (int i = 0; i < 8; i++) begin
         send0(pat_t[i]);
         check_val("t3_level", {31'd0, level_out}, {31'd0, pat_lvl[i]});
         if (i < 7) begin
            for (int g = 0; g < 3; g++) begin
               step();
               check_val("t3_gap_level", {31'd0, level_out}, {31'd0, pat_lvl[i]});
               check_val("t3_gap_valid", {31'd0, word_valid}, 32'd0);
            end
         end
      end
      check_val("t3_valid", {31'd0, word_valid}, 32'd1);
      check_val("t3_word",  {24'd0, word_out}, 32'h37);
      step();
      check_val("t3_consumed", {31'd0, word_valid}, 32'd0);

      // 4: consumer stalled, second word dropped
      word_ready = 1'b0;
      send_pat("t4a");
      check_val("t4_valid1", {31'd0, word_valid}, 32'd1);
      check_val("t4_word1",  {24'd0, word_out}, 32'h37);
      for (int i = 0; i < 8; i++) begin
         send0(1'b0);
         if (i < 7) check_val("t4_ovf_early", {31'd0, overflow}, 32'd0);
      end
      check_val("t4_ovf",  {31'd0, overflow}, 32'd1);
      check_val("t4_hold", {24'd0, word_out}, 32'h37);
      check_val("t4_hold_valid", {31'd0, word_valid}, 32'd1);
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      check_val("t4_tcount", {28'd0, tcount}, 32'd4);
`endif
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      check_val("t4_clr", {31'd0, overflow}, 32'd0);
      check_val("t4_clr_word", {24'd0, word_out}, 32'h37);
      word_ready = 1'b1; step(); word_ready = 1'b0;
      check_val("t4_consumed", {31'd0, word_valid}, 32'd0);

      // 5: ready arrives in the very cycle the next word completes
      send_pat("t5a");
      check_val("t5_word1", {24'd0, word_out}, 32'h37);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) word_ready = 1'b1;
         send0(1'b0);
      end
      check_val("t5_ovf",   {31'd0, overflow}, 32'd0);
      check_val("t5_valid", {31'd0, word_valid}, 32'd1);
      check_val("t5_word2", {24'd0, word_out}, 32'h00);
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      check_val("t5_tcount", {28'd0, tcount}, 32'd0);
`endif
      step(); word_ready = 1'b0;
      check_val("t5_consumed", {31'd0, word_valid}, 32'd0);

      // 5b: drop and clr_ovf in the same cycle, set wins
      for (int i = 0; i < 8; i++) send0(1'b0);
      check_val("t5b_valid", {31'd0, word_valid}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) clr_ovf = 1'b1;
         send0(1'b0);
      end
      clr_ovf = 1'b0;
      check_val("t5b_set_wins", {31'd0, overflow}, 32'd1);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      check_val("t5b_clr", {31'd0, overflow}, 32'd0);

      // 6: INIT_LEVEL=1, reset mid-word discards partial bits
      for (int i = 0; i < 5; i++) send1(t1_bits[i]);
      check_val("t6_partial_level", {31'd0, level1_out}, 32'd0);
      reset1 = 1'b1; step(); reset1 = 1'b0;
      check_val("t6_rst_level", {31'd0, level1_out}, 32'd1);
      check_val("t6_rst_valid", {31'd0, word1_valid}, 32'd0);
      check_val("t6_rst_word",  {24'd0, word1_out}, 32'h00);
      for (int i = 0; i < 8; i++) begin
         send1(1'b0);
         check_val("t6_level", {31'd0, level1_out}, 32'd1);
         check_val("t6_valid", {31'd0, word1_valid}, (i == 7) ? 32'd1 : 32'd0);
      end
      check_val("t6_word", {24'd0, word1_out}, 32'hFF);
`ifdef TOGGLE_STREAM_DECODER_TCOUNT_EN
      check_val("t6_tcount", {28'd0, tcount1}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
